// File: rtl/seq_mult_rs_param.sv
// Sequential shift-add multiplier. It handles unsigned operands directly and
// signed operands with radix-2 Booth recoding.
// Accept edge -> WIDTH iteration edges -> one result edge. The result edge
// writes product and pulses done, for a latency of WIDTH+1 cycles.
module seq_mult_rs_param #(
  parameter int unsigned WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 tc,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned AW = 2 * WIDTH + 1;
  localparam int unsigned UW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  acc_nxt;
  logic [WIDTH-1:0] b_q;
  logic           tc_q;
  logic           qm1;
  logic [CW-1:0]  cnt;
  logic           accept_c;
  logic           last_c;
  logic           iter_c;
  logic [UW-1:0]  upper_c;
  logic [UW-1:0]  b_ext_c;
  logic [UW-1:0]  sum_c;
  logic           do_add_c;
  logic           do_sub_c;

  // Next-state logic and control strobes
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    iter_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_c  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH)) begin
          last_c    = 1'b1;
          state_nxt = IDLE;
        end else begin
          iter_c = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration: conditional add/subtract into the upper half, then shift right
  always_comb begin
    upper_c  = acc[AW-1:WIDTH];
    b_ext_c  = tc_q ? {b_q[WIDTH-1], b_q} : {1'b0, b_q};
    do_sub_c = tc_q & acc[0] & ~qm1;
    do_add_c = tc_q ? (~acc[0] & qm1) : acc[0];
    sum_c    = upper_c;
    if (do_add_c) begin
      sum_c = upper_c + b_ext_c;
    end else if (do_sub_c) begin
      sum_c = upper_c - b_ext_c;
    end
    acc_nxt = {tc_q & sum_c[WIDTH], sum_c, acc[WIDTH-1:1]};
  end

  // State register and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= last_c;
    end
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc     <= '0;
      b_q     <= '0;
      tc_q    <= 1'b0;
      qm1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      if (accept_c) begin
        acc  <= {UW'(0), a};
        b_q  <= b;
        tc_q <= tc;
        qm1  <= 1'b0;
        cnt  <= '0;
      end else if (iter_c) begin
        acc <= acc_nxt;
        qm1 <= acc[0];
        cnt <= cnt + CW'(1);
      end
      if (last_c) begin
        product <= acc[PW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_rs_param.sv
// Self-checking bench for seq_mult_rs_param at WIDTH 6, 16 and 2.
// Expected products come from plain integer arithmetic.
module tb_seq_mult_rs_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        tc;
  logic [31:0] a_bus;
  logic [31:0] b_bus;
  logic        start6, start16, start2;
  logic        busy6, busy16, busy2;
  logic        done6, done16, done2;
  logic [11:0] prod6;
  logic [31:0] prod16;
  logic [3:0]  prod2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_mult_rs_param #(.WIDTH(6)) u_w6 (
    .clk(clk), .rst(rst), .start(start6), .tc(tc),
    .a(a_bus[5:0]), .b(b_bus[5:0]),
    .busy(busy6), .done(done6), .product(prod6));

  seq_mult_rs_param #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(start16), .tc(tc),
    .a(a_bus[15:0]), .b(b_bus[15:0]),
    .busy(busy16), .done(done16), .product(prod16));

  seq_mult_rs_param #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst), .start(start2), .tc(tc),
    .a(a_bus[1:0]), .b(b_bus[1:0]),
    .busy(busy2), .done(done2), .product(prod2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: sign/zero-extend to 64 bits, multiply, keep 2*w bits
  function automatic logic [63:0] ref_prod(input int w, input bit tcm,
                                           input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] m;
    longint sa, sb;
    m  = (64'd1 << w) - 64'd1;
    sa = longint'({32'd0, av} & m);
    sb = longint'({32'd0, bv} & m);
    if (tcm && sa[w-1]) sa = sa - (longint'(1) << w);
    if (tcm && sb[w-1]) sb = sb - (longint'(1) << w);
    return 64'(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  function automatic logic [63:0] get_prod(input int w);
    case (w)
      6:  return 64'(prod6);
      16: return 64'(prod16);
      default: return 64'(prod2);
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      6:  return busy6;
      16: return busy16;
      default: return busy2;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      6:  return done6;
      16: return done16;
      default: return done2;
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      6:  start6 = v;
      16: start16 = v;
      default: start2 = v;
    endcase
  endtask

  // Issue one op from an idle cycle (time = posedge+1) and stop in the done cycle
  task automatic run_op(input int w, input bit tcm, input logic [31:0] av,
                        input logic [31:0] bv, output logic [63:0] prod_o);
    logic [63:0] exp;
    logic [63:0] hold;
    int n;
    bit held;
    exp  = ref_prod(w, tcm, av, bv);
    hold = get_prod(w);
    a_bus = av; b_bus = bv; tc = tcm;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    check("busy_after_accept", 64'(get_busy(w)), 64'd1);
    n = 0;
    held = 1'b1;
    while (get_done(w) !== 1'b1 && n <= w + 4) begin
      if (get_prod(w) !== hold) held = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'(w + 1));
    check("product_held_during_run", 64'(held), 64'd1);
    check("product", get_prod(w), exp);
    check("busy_low_at_done", 64'(get_busy(w)), 64'd0);
    prod_o = get_prod(w);
  endtask

  // Full op followed by one cycle confirming the done pulse ends and product holds
  task automatic op(input int w, input bit tcm, input logic [31:0] av,
                    input logic [31:0] bv, output logic [63:0] prod_o);
    run_op(w, tcm, av, bv, prod_o);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(get_done(w)), 64'd0);
    check("product_after_done", get_prod(w), prod_o);
  endtask

  initial begin
    logic [63:0] p;
    int n;
    rst = 1'b0; tc = 1'b0; a_bus = '0; b_bus = '0;
    start6 = 1'b0; start16 = 1'b0; start2 = 1'b0;

    // Reset state, with start held high to show reset dominates
    start6 = 1'b1; start16 = 1'b1; start2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start6 = 1'b0; start16 = 1'b0; start2 = 1'b0;
    check("rst_busy6", 64'(busy6), 64'd0);
    check("rst_done6", 64'(done6), 64'd0);
    check("rst_prod6", 64'(prod6), 64'd0);
    check("rst_busy16", 64'(busy16), 64'd0);
    check("rst_prod2", 64'(prod2), 64'd0);
    rst = 1'b1;

    // Directed WIDTH=6 corner cases
    op(6, 1'b0, 32'd63, 32'd63, p);  check("u_63x63", p, 64'hF81);
    op(6, 1'b1, 32'h20, 32'h20, p);  check("s_min_x_min", p, 64'h400);
    op(6, 1'b1, 32'h3F, 32'd31, p);  check("s_m1_x_31", p, 64'hFE1);
    op(6, 1'b0, 32'd0, 32'd45, p);   check("u_zero_a", p, 64'h0);
    op(6, 1'b0, 32'd37, 32'd0, p);   check("u_zero_b", p, 64'h0);
    op(6, 1'b1, 32'h20, 32'h1F, p);  check("s_min_x_max", p, 64'hC20);

    // Back-to-back with a spurious start while busy
    a_bus = 32'd5; b_bus = 32'd9; tc = 1'b0; start6 = 1'b1;
    @(posedge clk); #1;
    start6 = 1'b0;
    n = 0;
    while (done6 !== 1'b1 && n <= 10) begin
      @(posedge clk); #1;
      n++;
      if (n == 3) begin
        start6 = 1'b1; a_bus = 32'd60; b_bus = 32'd60; tc = 1'b1;
      end else if (n == 4) begin
        start6 = 1'b0; tc = 1'b0;
      end
    end
    check("b2b_first_latency", 64'(n), 64'd7);
    check("b2b_first_product", 64'(prod6), 64'd45);
    a_bus = 32'd7; b_bus = 32'd7; tc = 1'b0; start6 = 1'b1;
    @(posedge clk); #1;
    start6 = 1'b0;
    check("b2b_second_accepted", 64'(busy6), 64'd1);
    check("b2b_done_cleared", 64'(done6), 64'd0);
    check("b2b_product_held", 64'(prod6), 64'd45);
    n = 0;
    while (done6 !== 1'b1 && n <= 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_second_latency", 64'(n), 64'd7);
    check("b2b_second_product", 64'(prod6), 64'd49);
    @(posedge clk); #1;

    // Reset in the middle of an operation
    a_bus = 32'd10; b_bus = 32'd10; tc = 1'b0; start6 = 1'b1;
    @(posedge clk); #1;
    start6 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("abort_busy", 64'(busy6), 64'd0);
    check("abort_done", 64'(done6), 64'd0);
    check("abort_product", 64'(prod6), 64'd0);
    op(6, 1'b0, 32'd2, 32'd3, p);    check("after_abort", p, 64'd6);

    // WIDTH=16 boundaries
    op(16, 1'b1, 32'h8000, 32'h8000, p); check("w16_s_min_sq", p, 64'h4000_0000);
    op(16, 1'b0, 32'hFFFF, 32'hFFFF, p); check("w16_u_max_sq", p, 64'hFFFE_0001);

    // Random regression, both modes, WIDTH=16 and WIDTH=2
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 1000; i++) begin
        op(16, m[0], $urandom, $urandom, p);
      end
      for (int i = 0; i < 1000; i++) begin
        op(2, m[0], $urandom, $urandom, p);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
